// File: rtl/rom_read_arbiter_if.sv
// Bundle of signals between the ROM read arbiter, its requesters and the ROM.
// The slave modport is the arbiter's view; master is the environment's view.
interface rom_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32
) ();
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_q;
   logic                      busy;

   modport slave (
      input  req, req_addr, rom_q,
      output grant, rd_valid, rd_data, rom_addr, busy
   );

   modport master (
      output req, req_addr, rom_q,
      input  grant, rd_valid, rd_data, rom_addr, busy
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM among NUM_REQ
// requesters. One read in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
// The winner gets a one-cycle grant, then a one-cycle rd_valid with the word.
module rom_read_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int ROM_LATENCY = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   rom_read_arbiter_if.slave   bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (ROM_LATENCY > 2) ? $clog2(ROM_LATENCY) : 1;
   // WAIT lasts ROM_LATENCY-1 cycles; the counter runs down to zero inclusive
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((ROM_LATENCY > 1) ? ROM_LATENCY - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;

   logic [ADDR_W-1:0]    req_addr_arr [NUM_REQ];
   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Rotating priority: scan downward so the candidate nearest rr_ptr+1 is kept last
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and registered-output logic; pulses default to zero every cycle
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      win_d      = win_q;
      rr_ptr_d   = rr_ptr_q;
      rd_data_d  = rd_data_q;
      grant_d    = '0;
      rd_valid_d = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               win_d            = win_idx;
               addr_d           = req_addr_arr[win_idx];
               rr_ptr_d         = win_idx;
               grant_d[win_idx] = 1'b1;
               state_d          = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ROM_LATENCY == 1) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DONE: begin
            rd_data_d         = bus.rom_q;
            rd_valid_d[win_q] = 1'b1;
            addr_d            = '0;   // rom_addr idles at zero
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset drops any read in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         win_q      <= '0;
         rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
         grant_q    <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         win_q      <= win_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rom_addr = addr_q;
   assign bus.busy     = (state_q != S_IDLE);
endmodule
